// File: rtl/data_c_rr_merge_if.sv
// Bundle of the NUM upstream data_inf_c streams and the single merged downstream stream.
// Handshake: a word moves on any stream in the cycle where valid && ready are both high at the clock edge.
interface data_c_rr_merge_if #(
  parameter int NUM    = 3,
  parameter int DSIZE  = 8,
  parameter int IDSIZE = $clog2(NUM)
);
  logic [NUM*DSIZE-1:0] s_data;
  logic [NUM-1:0]       s_valid;
  logic [NUM-1:0]       s_ready;
  logic [DSIZE-1:0]     m_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [IDSIZE-1:0]    m_sid;

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_sid
  );

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_sid
  );
endinterface

// File: rtl/data_c_rr_merge.sv
// Round-robin merge of NUM byte streams into one registered output stream,
// each output word tagged with the index of the stream it came from.
module data_c_rr_merge #(
  parameter int NUM    = 3,
  parameter int DSIZE  = 8,
  parameter int IDSIZE = $clog2(NUM)
) (
  input  logic              clock,
  input  logic              rst_n,
  data_c_rr_merge_if.slave  bus
);

  logic [DSIZE-1:0]  r_data;
  logic              r_valid;
  logic [IDSIZE-1:0] r_sid;
  logic [IDSIZE-1:0] r_ptr;

  logic              w_ld;
  logic              w_any;
  logic              w_hi_found;
  logic [IDSIZE-1:0] w_hi;
  logic [IDSIZE-1:0] w_lo;
  logic [IDSIZE-1:0] w_grant;
  logic [DSIZE-1:0]  w_hi_data;
  logic [DSIZE-1:0]  w_lo_data;
  logic [DSIZE-1:0]  w_gdata;
  logic [NUM-1:0]    w_ready;

  assign w_ld  = !r_valid || bus.m_ready;
  assign w_any = |bus.s_valid;

  // Scanning from ptr with wrap equals: lowest valid index >= ptr if one exists,
  // otherwise lowest valid index overall. Descending loop leaves the lowest match.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    w_hi_data  = '0;
    w_lo_data  = '0;
    for (int i = NUM - 1; i >= 0; i--) begin
      if (bus.s_valid[i]) begin
        w_lo      = IDSIZE'(i);
        w_lo_data = bus.s_data[i*DSIZE +: DSIZE];
        if (IDSIZE'(i) >= r_ptr) begin
          w_hi_found = 1'b1;
          w_hi       = IDSIZE'(i);
          w_hi_data  = bus.s_data[i*DSIZE +: DSIZE];
        end
      end
    end
  end

  assign w_grant = w_hi_found ? w_hi : w_lo;
  assign w_gdata = w_hi_found ? w_hi_data : w_lo_data;

  // rst_n gating keeps every s_ready low while reset is held, so no handshake completes then.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < NUM; i++) begin
      w_ready[i] = rst_n && w_ld && w_any && (w_grant == IDSIZE'(i));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_sid   <= '0;
      r_ptr   <= '0;
    end else if (w_ld) begin
      if (w_any) begin
        r_data  <= w_gdata;
        r_sid   <= w_grant;
        r_valid <= 1'b1;
        r_ptr   <= (w_grant == IDSIZE'(NUM - 1)) ? '0 : w_grant + IDSIZE'(1);
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ready = w_ready;
  assign bus.m_data  = r_data;
  assign bus.m_valid = r_valid;
  assign bus.m_sid   = r_sid;

endmodule

// File: tb/tb_data_c_rr_merge.sv
// Directed checks of the round-robin merge on a NUM=3 instance, plus a
// per-stream ordering, fairness and stability sweep on a NUM=5 instance.
module tb_data_c_rr_merge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_c_rr_merge_if #(.NUM(3), .DSIZE(8)) b3 ();
  data_c_rr_merge_if #(.NUM(5), .DSIZE(8)) b5 ();

  data_c_rr_merge #(.NUM(3), .DSIZE(8)) u_dut3 (.clock(clk), .rst_n(rst_n), .bus(b3));
  data_c_rr_merge #(.NUM(5), .DSIZE(8)) u_dut5 (.clock(clk), .rst_n(rst_n), .bus(b5));

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_q [5][$];
  logic [4:0] seq_c [5];
  int         wait_c [5];
  logic       prev_stall;
  logic [7:0] prev_d;
  logic [2:0] prev_sid;
  int         alt_g [4] = '{2, 0, 2, 0};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic [2:0] v, input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic mr);
    b3.s_valid = v;
    b3.s_data  = {d2, d1, d0};
    b3.m_ready = mr;
  endtask

  task automatic chk_out3(input string tag, input logic v, input logic [7:0] d, input logic [1:0] sid);
    check({tag, "_valid"}, 32'(b3.m_valid), 32'(v));
    check({tag, "_data"},  32'(b3.m_data),  32'(d));
    check({tag, "_sid"},   32'(b3.m_sid),   32'(sid));
  endtask

  // Called at the negedge: consume the output word, then record accepted inputs.
  task automatic mon5();
    logic [2:0] sid;
    logic [7:0] want;
    if (prev_stall) begin
      check("rnd_stable_data", 32'(b5.m_data), 32'(prev_d));
      check("rnd_stable_sid",  32'(b5.m_sid),  32'(prev_sid));
    end
    check("rnd_onehot_ready", 32'($countones(b5.s_ready) <= 1), 32'd1);
    if (b5.m_valid && b5.m_ready) begin
      sid = b5.m_sid;
      check("rnd_sid_range", 32'(sid < 3'd5), 32'd1);
      if (sid < 3'd5) begin
        check("rnd_no_dup", 32'(exp_q[sid].size() != 0), 32'd1);
        if (exp_q[sid].size() != 0) begin
          want = exp_q[sid].pop_front();
          check("rnd_order_data", 32'(b5.m_data), 32'(want));
        end
      end
    end
    prev_stall = b5.m_valid && !b5.m_ready;
    prev_d     = b5.m_data;
    prev_sid   = b5.m_sid;
    for (int i = 0; i < 5; i++) begin
      if (b5.s_valid[i]) begin
        if (b5.s_ready[i]) begin
          check("rnd_wait_bound", 32'(wait_c[i] <= 4), 32'd1);
          wait_c[i] = 0;
          exp_q[i].push_back(b5.s_data[i*8 +: 8]);
          seq_c[i] = seq_c[i] + 5'd1;
        end else if (|b5.s_ready) begin
          wait_c[i]++;
        end
      end else begin
        wait_c[i] = 0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive3(3'b111, 8'h01, 8'h02, 8'h03, 1'b0);
    b5.s_valid = '0;
    b5.s_data  = '0;
    b5.m_ready = 1'b1;
    prev_stall = 1'b0;
    prev_d     = '0;
    prev_sid   = '0;
    for (int i = 0; i < 5; i++) begin
      seq_c[i]  = '0;
      wait_c[i] = 0;
    end

    // reset state, inputs valid but nothing may be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out3("reset", 1'b0, 8'h00, 2'd0);
    check("reset_ready", 32'(b3.s_ready), 32'd0);

    // single stream 1
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive3(3'b010, 8'h00, 8'h5A, 8'h00, 1'b1);
    @(negedge clk);
    check("t1_ready", 32'(b3.s_ready), 32'b010);
    step();
    drive3(3'b011, 8'h33, 8'h44, 8'h00, 1'b1);
    @(negedge clk);
    chk_out3("t1_out", 1'b1, 8'h5A, 2'd1);
    check("t1_ptr2_ready", 32'(b3.s_ready), 32'b001);
    step();
    drive3(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    chk_out3("t1b_out", 1'b1, 8'h33, 2'd0);
    step();
    drive3(3'b111, 8'h01, 8'h02, 8'h03, 1'b0);
    @(negedge clk);
    chk_out3("pre_rst_hold", 1'b1, 8'h33, 2'd0);
    check("pre_rst_ready", 32'(b3.s_ready), 32'd0);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk_out3("async_rst", 1'b0, 8'h00, 2'd0);
    check("async_rst_ready", 32'(b3.s_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all streams valid: grants 0,1,2,0,1,2 from ptr 0, no bubbles
    drive3(3'b111, 8'h10, 8'h11, 8'h12, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) chk_out3($sformatf("rr%0d", k - 1), 1'b1, 8'h10 + 8'((k - 1) % 3), 2'((k - 1) % 3));
      check($sformatf("rr%0d_ready", k), 32'(b3.s_ready), 32'(1 << (k % 3)));
      step();
    end
    drive3(3'b100, 8'h00, 8'h00, 8'h22, 1'b1);
    @(negedge clk);
    chk_out3("rr5", 1'b1, 8'h12, 2'd2);
    check("load22_ready", 32'(b3.s_ready), 32'b100);
    step();

    // back-pressure with all inputs valid
    drive3(3'b111, 8'h20, 8'h21, 8'h23, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_out3($sformatf("stall%0d", k), 1'b1, 8'h22, 2'd2);
      check($sformatf("stall%0d_ready", k), 32'(b3.s_ready), 32'd0);
      step();
    end
    drive3(3'b111, 8'h20, 8'h21, 8'h23, 1'b1);
    @(negedge clk);
    chk_out3("stall_end", 1'b1, 8'h22, 2'd2);
    check("resume_ready", 32'(b3.s_ready), 32'b001);
    step();

    // streams 0 and 2 only, ptr 1: grants alternate 2,0,2,0
    drive3(3'b101, 8'hA0, 8'h00, 8'hA2, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk_out3("resume_out", 1'b1, 8'h20, 2'd0);
      else chk_out3($sformatf("alt%0d", k - 1), 1'b1, (alt_g[k-1] == 2) ? 8'hA2 : 8'hA0, 2'(alt_g[k-1]));
      check($sformatf("alt%0d_ready", k), 32'(b3.s_ready), 32'(1 << alt_g[k]));
      step();
    end
    drive3(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
    @(negedge clk);
    chk_out3("alt3", 1'b1, 8'hA0, 2'd0);
    step();
    @(negedge clk);
    check("idle_valid", 32'(b3.m_valid), 32'd0);
    step();

    // NUM=5 sweep with random valid/ready
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 5; i++) begin
        b5.s_valid[i]       = ($urandom_range(0, 3) != 0);
        b5.s_data[i*8 +: 8] = {3'(i), seq_c[i]};
      end
      b5.m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      mon5();
      step();
    end
    b5.s_valid = '0;
    b5.m_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      mon5();
      step();
    end
    for (int i = 0; i < 5; i++) check($sformatf("rnd_drain%0d", i), 32'(exp_q[i].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
